// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer.
// Holds the default frame geometry (lanes per beat, beats per frame, log2 of
// the point count), the per-bank occupancy states, the read controller
// states, and the bit-reversal helper used to turn natural-order output
// indices into pipeline-order buffer addresses.
package fft_pkg;

   localparam int N               = 16;
   localparam int TOTAL_BLOCK_CNT = 32;
   localparam int LOG2_PTS        = 9;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      FILLING = 2'd1,
      READY   = 2'd2,
      READING = 2'd3
   } bank_state_e;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_e;

   // Reverses the low 'width' bits of 'value'; bits above 'width' come back as
   // zero. Built by shifting one bit at a time so no variable bit index is
   // needed and the loop unrolls to pure wiring for a constant width.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] src;
      logic [31:0] res;
      src = value;
      res = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            res = {res[30:0], src[0]};
            src = {1'b0, src[31:1]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One bank of the reorder ping-pong buffer.
// Holds one full frame (N*BEATS complex samples). A whole beat is written at
// once into consecutive addresses {beat, lane}; every lane has its own
// arbitrary read address so a bit-reversed gather can be done in one cycle.
// Contents are never reset: a frame is always fully rewritten before reuse.
//
// Ports:
//   clk       rising-edge clock
//   we_i      write the beat on wrRe_i/wrIm_i this cycle
//   wrBeat_i  beat number, selects address row wrBeat_i*N
//   wrRe_i    real parts for lanes 0..N-1
//   wrIm_i    imaginary parts for lanes 0..N-1
//   rdAddr_i  per-lane read address
//   rdRe_o    real part stored at rdAddr_i[lane] (combinational read)
//   rdIm_o    imaginary part stored at rdAddr_i[lane]
module fft_reorder_bank #(
   parameter int W     = 13,
   parameter int N     = 16,
   parameter int BEATS = 32
) (
   input  logic                         clk,
   input  logic                         we_i,
   input  logic [$clog2(BEATS)-1:0]     wrBeat_i,
   input  logic signed [W-1:0]          wrRe_i   [N],
   input  logic signed [W-1:0]          wrIm_i   [N],
   input  logic [$clog2(BEATS*N)-1:0]   rdAddr_i [N],
   output logic signed [W-1:0]          rdRe_o   [N],
   output logic signed [W-1:0]          rdIm_o   [N]
);

   localparam int LW    = $clog2(N);
   localparam int DEPTH = BEATS * N;

   logic signed [W-1:0] memRe_q [DEPTH];
   logic signed [W-1:0] memIm_q [DEPTH];

   // Beat write: lane j lands at address {beat, j}, i.e. beat*N + j.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int j = 0; j < N; j++) begin
            memRe_q[{wrBeat_i, LW'(j)}] <= wrRe_i[j];
            memIm_q[{wrBeat_i, LW'(j)}] <= wrIm_i[j];
         end
      end
   end

   // Gather read: each lane looks up its own address independently.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         rdRe_o[j] = memRe_q[rdAddr_i[j]];
         rdIm_o[j] = memIm_q[rdAddr_i[j]];
      end
   end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer.
// Accepts frames of TOTAL_BLOCK_CNT beats, N complex lanes each, arriving in
// bit-reversed pipeline order, and emits them in natural order. Two banks
// ping-pong: while one frame is read out the next one is written into the
// other bank. Output frames are always emitted on consecutive cycles, and a
// second ready frame follows the first without a bubble.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   valid_in   din_i/din_q carry a beat this cycle (no backpressure)
//   din_i      real parts, pipeline order
//   din_q      imaginary parts, pipeline order
//   valid_out  dout_i/dout_q carry a beat
//   dout_i     real parts, natural order (0 when valid_out is low)
//   dout_q     imaginary parts, natural order (0 when valid_out is low)
//   sop_out    first beat of an output frame
//   eop_out    last beat of an output frame
//   overflow   sticky: a beat arrived while its target bank was still busy
module fft_out_reorder #(
   parameter int IN_BIT_WIDTH    = 13,
   parameter int N               = fft_pkg::N,
   parameter int TOTAL_BLOCK_CNT = fft_pkg::TOTAL_BLOCK_CNT,
   parameter int LOG2_PTS        = fft_pkg::LOG2_PTS
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           valid_in,
   input  logic signed [IN_BIT_WIDTH-1:0] din_i  [0:N-1],
   input  logic signed [IN_BIT_WIDTH-1:0] din_q  [0:N-1],
   output logic                           valid_out,
   output logic signed [IN_BIT_WIDTH-1:0] dout_i [0:N-1],
   output logic signed [IN_BIT_WIDTH-1:0] dout_q [0:N-1],
   output logic                           sop_out,
   output logic                           eop_out,
   output logic                           overflow
);

   import fft_pkg::*;

   localparam int BW = $clog2(TOTAL_BLOCK_CNT);
   localparam int LW = $clog2(N);
   localparam logic [BW-1:0] LAST_BEAT = BW'(TOTAL_BLOCK_CNT - 1);

   // Write side state
   logic              wrBank_q,   wrBank_d;
   logic [BW-1:0]     wrCnt_q,    wrCnt_d;
   logic              overflow_q, overflow_d;

   // Shared bank occupancy, updated by both the write side and the reader
   bank_state_e [1:0] bankState_q, bankState_d;

   // Read side state
   rd_state_e         rdState_q, rdState_d;
   logic              rdBank_q,  rdBank_d;
   logic [BW-1:0]     rdCnt_q,   rdCnt_d;

   // Registered outputs
   logic                           validOut_q, validOut_d;
   logic                           sop_q,      sop_d;
   logic                           eop_q,      eop_d;
   logic signed [IN_BIT_WIDTH-1:0] doutRe_q [N];
   logic signed [IN_BIT_WIDTH-1:0] doutIm_q [N];
   logic signed [IN_BIT_WIDTH-1:0] doutRe_d [N];
   logic signed [IN_BIT_WIDTH-1:0] doutIm_d [N];

   // Datapath between the banks and the output registers
   logic [LOG2_PTS-1:0]            rdAddr  [N];
   logic signed [IN_BIT_WIDTH-1:0] bank0Re [N];
   logic signed [IN_BIT_WIDTH-1:0] bank0Im [N];
   logic signed [IN_BIT_WIDTH-1:0] bank1Re [N];
   logic signed [IN_BIT_WIDTH-1:0] bank1Im [N];
   logic signed [IN_BIT_WIDTH-1:0] rdRe    [N];
   logic signed [IN_BIT_WIDTH-1:0] rdIm    [N];

   logic rdActive;
   logic rdDone;
   logic nextBank;
   logic nextReady;
   logic wrTargetFree;
   logic wrAccept;
   logic we0;
   logic we1;

   // rdBank_q always names the bank being read (READ) or the bank to read
   // next (IDLE). Banks fill strictly in alternation, so the next bank in
   // line is automatically the oldest READY one.
   assign rdActive  = (rdState_q == READ);
   assign rdDone    = rdActive && (rdCnt_q == LAST_BEAT);
   assign nextBank  = rdActive ? ~rdBank_q : rdBank_q;
   assign nextReady = (bankState_q[nextBank] == READY);

   // A bank whose final beat is being read this cycle may already take the
   // first beat of the next frame: the read data is taken before the write
   // lands at the clock edge. This is what lets frames run back-to-back at
   // full rate without spurious overflow.
   assign wrTargetFree = (bankState_q[wrBank_q] == FREE)    ||
                         (bankState_q[wrBank_q] == FILLING) ||
                         (rdDone && (rdBank_q == wrBank_q));
   assign wrAccept = valid_in && wrTargetFree;
   assign we0      = wrAccept && (wrBank_q == 1'b0);
   assign we1      = wrAccept && (wrBank_q == 1'b1);

   // Read controller and write-side bookkeeping. Read-side bank updates are
   // applied first so that, if a bank is freed and written in the same cycle,
   // the write side's FILLING wins.
   always_comb begin
      rdState_d   = rdState_q;
      rdBank_d    = rdBank_q;
      rdCnt_d     = rdCnt_q;
      bankState_d = bankState_q;
      wrBank_d    = wrBank_q;
      wrCnt_d     = wrCnt_q;
      overflow_d  = overflow_q || (valid_in && !wrTargetFree);

      case (rdState_q)
         IDLE: begin
            if (nextReady) begin
               rdState_d             = READ;
               rdCnt_d               = '0;
               bankState_d[rdBank_q] = READING;
            end
         end
         READ: begin
            rdCnt_d = rdCnt_q + 1'b1;
            if (rdDone) begin
               bankState_d[rdBank_q] = FREE;
               rdBank_d              = ~rdBank_q;
               rdCnt_d               = '0;
               if (nextReady) begin
                  bankState_d[~rdBank_q] = READING;
               end else begin
                  rdState_d = IDLE;
               end
            end
         end
         default: begin
            rdState_d = IDLE;
         end
      endcase

      if (wrAccept) begin
         if (wrCnt_q == LAST_BEAT) begin
            bankState_d[wrBank_q] = READY;
            wrBank_d              = ~wrBank_q;
            wrCnt_d               = '0;
         end else begin
            bankState_d[wrBank_q] = FILLING;
            wrCnt_d               = wrCnt_q + 1'b1;
         end
      end
   end

   // Natural-order index k*N+j maps to pipeline-order address bitrev(k*N+j).
   always_comb begin
      for (int j = 0; j < N; j++) begin
         rdAddr[j] = LOG2_PTS'(bitrev(32'({rdCnt_q, LW'(j)}), LOG2_PTS));
      end
   end

   fft_reorder_bank #(
      .W     (IN_BIT_WIDTH),
      .N     (N),
      .BEATS (TOTAL_BLOCK_CNT)
   ) u_bank0 (
      .clk      (clk),
      .we_i     (we0),
      .wrBeat_i (wrCnt_q),
      .wrRe_i   (din_i),
      .wrIm_i   (din_q),
      .rdAddr_i (rdAddr),
      .rdRe_o   (bank0Re),
      .rdIm_o   (bank0Im)
   );

   fft_reorder_bank #(
      .W     (IN_BIT_WIDTH),
      .N     (N),
      .BEATS (TOTAL_BLOCK_CNT)
   ) u_bank1 (
      .clk      (clk),
      .we_i     (we1),
      .wrBeat_i (wrCnt_q),
      .wrRe_i   (din_i),
      .wrIm_i   (din_q),
      .rdAddr_i (rdAddr),
      .rdRe_o   (bank1Re),
      .rdIm_o   (bank1Im)
   );

   // Pick the bank being read and force the data to zero outside a frame.
   always_comb begin
      validOut_d = rdActive;
      sop_d      = rdActive && (rdCnt_q == '0);
      eop_d      = rdDone;
      for (int j = 0; j < N; j++) begin
         rdRe[j]     = rdBank_q ? bank1Re[j] : bank0Re[j];
         rdIm[j]     = rdBank_q ? bank1Im[j] : bank0Im[j];
         doutRe_d[j] = rdActive ? rdRe[j] : '0;
         doutIm_d[j] = rdActive ? rdIm[j] : '0;
      end
   end

   // All state registers. Reset abandons any partial frame on either side;
   // the buffer memories themselves are left untouched.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wrBank_q       <= 1'b0;
         wrCnt_q        <= '0;
         overflow_q     <= 1'b0;
         bankState_q[0] <= FREE;
         bankState_q[1] <= FREE;
         rdState_q      <= IDLE;
         rdBank_q       <= 1'b0;
         rdCnt_q        <= '0;
         validOut_q     <= 1'b0;
         sop_q          <= 1'b0;
         eop_q          <= 1'b0;
         for (int j = 0; j < N; j++) begin
            doutRe_q[j] <= '0;
            doutIm_q[j] <= '0;
         end
      end else begin
         wrBank_q    <= wrBank_d;
         wrCnt_q     <= wrCnt_d;
         overflow_q  <= overflow_d;
         bankState_q <= bankState_d;
         rdState_q   <= rdState_d;
         rdBank_q    <= rdBank_d;
         rdCnt_q     <= rdCnt_d;
         validOut_q  <= validOut_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         for (int j = 0; j < N; j++) begin
            doutRe_q[j] <= doutRe_d[j];
            doutIm_q[j] <= doutIm_d[j];
         end
      end
   end

   assign valid_out = validOut_q;
   assign sop_out   = sop_q;
   assign eop_out   = eop_q;
   assign overflow  = overflow_q;

   // Output lanes straight from their registers.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         dout_i[j] = doutRe_q[j];
         dout_q[j] = doutIm_q[j];
      end
   end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder.
// Frames are described as flat arrays indexed by pipeline position b*16+j.
// The reference model says output sample n of a frame equals input sample
// bitrev9(n); every sent frame pushes its 512 expected samples onto a queue
// that a negedge monitor drains against the DUT outputs.
module tb_fft_out_reorder;

   localparam int W     = 13;
   localparam int N     = 16;
   localparam int BEATS = 32;
   localparam int PTS   = N * BEATS;

   logic                clk = 1'b0;
   logic                rstn;
   logic                valid_in;
   logic signed [W-1:0] din_i  [0:N-1];
   logic signed [W-1:0] din_q  [0:N-1];
   logic                valid_out;
   logic signed [W-1:0] dout_i [0:N-1];
   logic signed [W-1:0] dout_q [0:N-1];
   logic                sop_out;
   logic                eop_out;
   logic                overflow;

   fft_out_reorder #(
      .IN_BIT_WIDTH    (W),
      .N               (N),
      .TOTAL_BLOCK_CNT (BEATS),
      .LOG2_PTS        (9)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .valid_in  (valid_in),
      .din_i     (din_i),
      .din_q     (din_q),
      .valid_out (valid_out),
      .dout_i    (dout_i),
      .dout_q    (dout_q),
      .sop_out   (sop_out),
      .eop_out   (eop_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Current frame being sent, and the saved random frames for the gap rerun
   int frameRe [PTS];
   int frameIm [PTS];
   int rndRe   [4][PTS];
   int rndIm   [4][PTS];

   // Model: expected output samples in order, and expected sop cycle per frame
   int expReQ [$];
   int expImQ [$];
   int latQ   [$];

   int outBeat = 0;
   int curRun  = 0;
   int lastRun = 0;
   int lastOutRe [PTS];
   int lastOutIm [PTS];

   typedef struct {
      int pattern;
      int beat;
      int lane;
      int expRe;
      int expIm;
   } vec_t;

   vec_t vecs [10];

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic int refBitrev(input int n);
      int r = 0;
      int v = n;
      for (int i = 0; i < 9; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   // 0: ramp a / -a, 1: all -4096 / +4095, 2: even lanes +4095 / odd -4096,
   // 3: uniformly random over the full signed range
   task automatic fillFrame(input int pattern);
      for (int a = 0; a < PTS; a++) begin
         case (pattern)
            0: begin frameRe[a] = a; frameIm[a] = -a; end
            1: begin frameRe[a] = -4096; frameIm[a] = 4095; end
            2: begin
               frameRe[a] = (a % 2 == 0) ? 4095 : -4096;
               frameIm[a] = (a % 2 == 0) ? -4096 : 4095;
            end
            default: begin
               frameRe[a] = int'($urandom_range(0, 8191)) - 4096;
               frameIm[a] = int'($urandom_range(0, 8191)) - 4096;
            end
         endcase
      end
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic loadBeat(input int b);
      for (int j = 0; j < N; j++) begin
         din_i[j] = W'(frameRe[b * N + j]);
         din_q[j] = W'(frameIm[b * N + j]);
      end
   endtask

   // Drive one beat of the current frame, optionally after random idle cycles
   task automatic applyStimulus(input int b, input bit withGaps);
      if (withGaps) begin
         while ($urandom_range(0, 1) == 1) idleCycle();
      end
      valid_in = 1'b1;
      loadBeat(b);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic sendFrame(input bit withGaps, input bit skipLat);
      for (int b = 0; b < BEATS; b++) applyStimulus(b, withGaps);
      latQ.push_back(skipLat ? -1 : cyc + 2);
      for (int n = 0; n < PTS; n++) begin
         expReQ.push_back(frameRe[refBitrev(n)]);
         expImQ.push_back(frameIm[refBitrev(n)]);
      end
   endtask

   task automatic flushModel();
      expReQ.delete();
      expImQ.delete();
      latQ.delete();
      outBeat = 0;
      curRun  = 0;
   endtask

   task automatic doReset(input int cycles);
      rstn     = 1'b0;
      valid_in = 1'b0;
      repeat (cycles) idleCycle();
      flushModel();
      rstn = 1'b1;
   endtask

   task automatic waitDrain();
      int budget = 400;
      while (expReQ.size() != 0 && budget > 0) begin
         idleCycle();
         budget--;
      end
      if (expReQ.size() != 0) checkOutput("drainTimeout", expReQ.size(), 0);
      repeat (2) idleCycle();
   endtask

   function automatic int anyDataNonZero();
      int nz = 0;
      for (int j = 0; j < N; j++) begin
         if (dout_i[j] != 0 || dout_q[j] != 0) nz = 1;
      end
      return nz;
   endfunction

   // Output monitor: scoreboard compare, framing flags, latency, contiguity
   always @(negedge clk) begin
      if (rstn) begin
         if (valid_out) begin
            curRun++;
            if (expReQ.size() < N) begin
               checkOutput("unexpectedBeat", 1, 0);
            end else begin
               if (outBeat == 0 && latQ.size() > 0) begin
                  int lat;
                  lat = latQ.pop_front();
                  if (lat >= 0) checkOutput("firstOutLatency", cyc, lat);
               end
               for (int j = 0; j < N; j++) begin
                  int er;
                  int ei;
                  er = expReQ.pop_front();
                  ei = expImQ.pop_front();
                  checkOutput("dataRe", int'(dout_i[j]), er);
                  checkOutput("dataIm", int'(dout_q[j]), ei);
                  lastOutRe[outBeat * N + j] = int'(dout_i[j]);
                  lastOutIm[outBeat * N + j] = int'(dout_q[j]);
               end
               checkOutput("sop", int'(sop_out), int'(outBeat == 0));
               checkOutput("eop", int'(eop_out), int'(outBeat == BEATS - 1));
               outBeat = (outBeat + 1) % BEATS;
            end
         end else begin
            if (curRun > 0) lastRun = curRun;
            curRun = 0;
            checkOutput("idleDataZero", anyDataNonZero(), 0);
            checkOutput("idleFlags", int'(sop_out | eop_out), 0);
            if (outBeat != 0) checkOutput("midFrameGap", outBeat, 0);
         end
      end
   end

   initial begin
      rstn     = 1'b0;
      valid_in = 1'b0;
      for (int j = 0; j < N; j++) begin
         din_i[j] = '0;
         din_q[j] = '0;
      end

      // Hand-derived probes into output frames: output n = input bitrev9(n)
      vecs[0] = '{0,  0,  1,   256,  -256};
      vecs[1] = '{0, 31, 15,   511,  -511};
      vecs[2] = '{0,  0,  0,     0,     0};
      vecs[3] = '{0,  0,  2,   128,  -128};
      vecs[4] = '{0,  2,  3,   392,  -392};
      vecs[5] = '{0, 16,  0,     1,    -1};
      vecs[6] = '{1,  0,  0, -4096,  4095};
      vecs[7] = '{1, 31, 15, -4096,  4095};
      vecs[8] = '{2,  0,  5,  4095, -4096};
      vecs[9] = '{2, 20,  3, -4096,  4095};

      idleCycle();
      doReset(3);
      checkOutput("rstValidOut", int'(valid_out), 0);
      checkOutput("rstSop", int'(sop_out), 0);
      checkOutput("rstEop", int'(eop_out), 0);
      checkOutput("rstOverflow", int'(overflow), 0);
      checkOutput("rstData", anyDataNonZero(), 0);

      // Directed single frames: ramp and extreme values
      for (int p = 0; p < 3; p++) begin
         fillFrame(p);
         sendFrame(1'b0, 1'b0);
         waitDrain();
         checkOutput("singleFrameRun", lastRun, BEATS);
         for (int v = 0; v < 10; v++) begin
            if (vecs[v].pattern == p) begin
               checkOutput($sformatf("vecRe%0d", v),
                           lastOutRe[vecs[v].beat * N + vecs[v].lane], vecs[v].expRe);
               checkOutput($sformatf("vecIm%0d", v),
                           lastOutIm[vecs[v].beat * N + vecs[v].lane], vecs[v].expIm);
            end
         end
      end

      // Four random frames back-to-back: one unbroken 128-beat output run
      for (int f = 0; f < 4; f++) begin
         fillFrame(3);
         rndRe[f] = frameRe;
         rndIm[f] = frameIm;
         sendFrame(1'b0, 1'b0);
      end
      waitDrain();
      checkOutput("fourFrameRun", lastRun, 4 * BEATS);
      checkOutput("fourFrameOverflow", int'(overflow), 0);

      // Same four frames with random input gaps: same data, contiguous frames
      for (int f = 0; f < 4; f++) begin
         frameRe = rndRe[f];
         frameIm = rndIm[f];
         sendFrame(1'b1, 1'b0);
      end
      waitDrain();
      checkOutput("gapRunOverflow", int'(overflow), 0);

      // Reset at beat 17 of frame 1 while frame 0 is still being read
      fillFrame(3);
      sendFrame(1'b0, 1'b0);
      fillFrame(3);
      for (int b = 0; b < 17; b++) applyStimulus(b, 1'b0);
      rstn     = 1'b0;
      valid_in = 1'b1;
      loadBeat(17);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      checkOutput("midRstValidOut", int'(valid_out), 0);
      checkOutput("midRstData", anyDataNonZero(), 0);
      checkOutput("midRstFlags", int'(sop_out | eop_out), 0);
      flushModel();
      rstn = 1'b1;
      fillFrame(0);
      sendFrame(1'b0, 1'b0);
      waitDrain();
      checkOutput("postRstRe", lastOutRe[1], 256);
      checkOutput("postRstIm", lastOutIm[511], -511);

      // Hold the reader off so both banks sit READY, then push one more beat
      doReset(2);
      force dut.nextReady = 1'b0;
      fillFrame(3);
      sendFrame(1'b0, 1'b1);
      fillFrame(3);
      sendFrame(1'b0, 1'b1);
      checkOutput("preOverflow", int'(overflow), 0);
      applyStimulus(0, 1'b0);
      checkOutput("overflowSet", int'(overflow), 1);
      checkOutput("heldNoOutput", int'(valid_out), 0);
      release dut.nextReady;
      waitDrain();
      checkOutput("overflowSticky", int'(overflow), 1);
      checkOutput("bufferedFramesRun", lastRun, 2 * BEATS);
      doReset(2);
      checkOutput("overflowCleared", int'(overflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
